// File: rtl/switch_pkg.sv
// Shared switch constants and types: packet layout, port count and the arbiter FSM states.
package switch_pkg;

    localparam int PKT_SIZE  = 16;
    localparam int NUM_PORTS = 4;
    localparam int IDX_W     = $clog2(NUM_PORTS);
    localparam int SRC_MSB   = 15;
    localparam int SRC_LSB   = 12;
    localparam int TGT_MSB   = 11;
    localparam int TGT_LSB   = 8;

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] tgt;
        logic [7:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant, wrapping around.
module rr_arbiter
    import switch_pkg::*;
#(
    parameter int N = NUM_PORTS,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any_gnt
);

    logic [W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester overwrites the others.
    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int off = N; off >= 1; off--) begin
            cand = W'((int'(last_grant) + off) % N);
            if (req[cand]) begin
                gnt_idx = cand;
                any_gnt = 1'b1;
            end
        end
        gnt_onehot = any_gnt ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port arbiter: reads one matching input FIFO round-robin and presents it as valid/ready.
// Optional OUT_ARB_DROP_INVALID_EN: port 0 also reads and discards packets with out-of-range targets.
module out_port_arbiter
#(
    parameter int PKT_SIZE  = switch_pkg::PKT_SIZE,
    parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
    parameter int PORT_ID   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*8-1:0]          hdr_in,
    input  logic [NUM_PORTS-1:0]            fifo_empty_in,
    input  logic [NUM_PORTS*PKT_SIZE-1:0]   fifo_data_in,
    output logic [NUM_PORTS-1:0]            rd_en_out,
    output logic [PKT_SIZE-1:0]             pkt_out,
    output logic                            pkt_valid,
    input  logic                            pkt_ready,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic [15:0]                     pkt_sent_cnt
`ifdef OUT_ARB_DROP_INVALID_EN
    , output logic [15:0]                   drop_cnt
`endif
);

    import switch_pkg::*;

    localparam int IW = $clog2(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        sel_q, sel_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        gid_q, gid_d;
    logic [PKT_SIZE-1:0]  pkt_q, pkt_d;
    logic                 valid_q, valid_d;
    logic [15:0]          sent_q, sent_d;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt_onehot;
    logic [IW-1:0]        gnt_idx;
    logic                 any_gnt;
    logic [PKT_SIZE-1:0]  load_pkt;
    logic                 drop_pkt;
    logic [NUM_PORTS*4-1:0] unused_hdr_src;

    // An empty FIFO shows a zero header, so emptiness must gate the target match.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
        logic [3:0] tgt;
        assign tgt = hdr_in[8*i +: 4];
        assign unused_hdr_src[4*i +: 4] = hdr_in[8*i+4 +: 4];
`ifdef OUT_ARB_DROP_INVALID_EN
        assign req[i] = !fifo_empty_in[i] &&
                        ((tgt == 4'(PORT_ID)) || ((PORT_ID == 0) && (int'(tgt) >= NUM_PORTS)));
`else
        assign req[i] = !fifo_empty_in[i] && (tgt == 4'(PORT_ID));
`endif
    end

    rr_arbiter #(.N(NUM_PORTS), .W(IW)) u_rr (
        .req        (req),
        .last_grant (last_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    assign load_pkt = fifo_data_in[int'(sel_q)*PKT_SIZE +: PKT_SIZE];

`ifdef OUT_ARB_DROP_INVALID_EN
    logic [15:0] drop_q, drop_d;
    assign drop_pkt = (PORT_ID == 0) && (int'(load_pkt[TGT_MSB:TGT_LSB]) >= NUM_PORTS);
    assign drop_cnt = drop_q;
`else
    assign drop_pkt = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        gid_d     = gid_q;
        pkt_d     = pkt_q;
        valid_d   = valid_q;
        sent_d    = sent_q;
        rd_en_out = '0;
`ifdef OUT_ARB_DROP_INVALID_EN
        drop_d    = drop_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_gnt && !rst) begin
                    rd_en_out = gnt_onehot;
                    sel_d     = gnt_idx;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                last_d = sel_q;
                gid_d  = sel_q;
                if (drop_pkt) begin
                    state_d = IDLE;
`ifdef OUT_ARB_DROP_INVALID_EN
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
`endif
                end else begin
                    pkt_d   = load_pkt;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (valid_q && pkt_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset mid-packet simply discards it; the FIFO entry already popped is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            gid_q   <= IW'(NUM_PORTS - 1);
            pkt_q   <= '0;
            valid_q <= 1'b0;
            sent_q  <= '0;
`ifdef OUT_ARB_DROP_INVALID_EN
            drop_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            sent_q  <= sent_d;
`ifdef OUT_ARB_DROP_INVALID_EN
            drop_q  <= drop_d;
`endif
        end
    end

    assign pkt_out      = pkt_q;
    assign pkt_valid    = valid_q;
    assign grant_id     = gid_q;
    assign pkt_sent_cnt = sent_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Self-checking bench for out_port_arbiter (PORT_ID 0) with modelled input FIFOs and a transaction-level reference.
module tb_out_port_arbiter;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*8-1:0] hdr_in;
    logic [NP-1:0]   fifo_empty_in;
    logic [NP*16-1:0] fifo_data_in;
    logic [NP-1:0]   rd_en_out;
    logic [15:0]     pkt_out;
    logic            pkt_valid;
    logic            pkt_ready = 1'b0;
    logic [1:0]      grant_id;
    logic [15:0]     pkt_sent_cnt;
`ifdef OUT_ARB_DROP_INVALID_EN
    logic [15:0]     drop_cnt;
`endif

    out_port_arbiter #(.PKT_SIZE(16), .NUM_PORTS(NP), .PORT_ID(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .hdr_in        (hdr_in),
        .fifo_empty_in (fifo_empty_in),
        .fifo_data_in  (fifo_data_in),
        .rd_en_out     (rd_en_out),
        .pkt_out       (pkt_out),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .grant_id      (grant_id),
        .pkt_sent_cnt  (pkt_sent_cnt)
`ifdef OUT_ARB_DROP_INVALID_EN
        , .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] fifoQ [NP][$];
    logic [15:0] dataReg [NP];

    bit          mBusy = 0;
    bit          mDrop = 0;
    int          mLast = NP - 1;
    int          mGrant = 0;
    int          gCycle = 0;
    int          cycleNo = 0;
    int          mSent = 0;
    int          mDrops = 0;
    logic [15:0] expData = '0;
    int          grantLog[$];
    int          rdSeen[NP];

    function automatic bit eligible(int i);
        logic [15:0] h;
        if (fifoQ[i].size() == 0) return 1'b0;
        h = fifoQ[i][0];
        if (h[11:8] == 4'd0) return 1'b1;
`ifdef OUT_ARB_DROP_INVALID_EN
        if (int'(h[11:8]) >= NP) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit anyEligible();
        for (int i = 0; i < NP; i++) if (eligible(i)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic driveFifo();
        for (int i = 0; i < NP; i++) begin
            fifo_empty_in[i]      = (fifoQ[i].size() == 0);
            hdr_in[8*i +: 8]      = (fifoQ[i].size() == 0) ? 8'h00 : fifoQ[i][0][15:8];
            fifo_data_in[16*i +: 16] = dataReg[i];
        end
    endtask

    // One clock: predict and compare at the falling edge, then let the FIFOs react to the sampled reads.
    task automatic cycle();
        int          expIdx;
        logic [NP-1:0] expRd;
        logic [NP-1:0] rdS;
        logic [15:0] peek;
        bit          hs;
        bit          dropNow;
        driveFifo();
        @(negedge clk);
        expRd = '0; expIdx = -1; hs = 0; dropNow = 0; peek = '0;
        if (!rst && !mBusy) begin
            for (int off = 1; off <= NP; off++) begin
                if (expIdx < 0 && eligible((mLast + off) % NP)) expIdx = (mLast + off) % NP;
            end
            if (expIdx >= 0) begin
                expRd[expIdx] = 1'b1;
                peek = fifoQ[expIdx][0];
            end
        end
        rdS = rd_en_out;
        checks++;
        if (rd_en_out !== expRd) begin
            errors++;
            $display("[TB] FAIL rd_en cyc%0d: got %b expected %b", cycleNo, rd_en_out, expRd);
        end
        if (!rst) begin
            checks++;
            if (pkt_sent_cnt !== 16'(mSent)) begin
                errors++;
                $display("[TB] FAIL sent_cnt cyc%0d: got %0d expected %0d", cycleNo, pkt_sent_cnt, mSent);
            end
`ifdef OUT_ARB_DROP_INVALID_EN
            checks++;
            if (drop_cnt !== 16'(mDrops)) begin
                errors++;
                $display("[TB] FAIL drop_cnt cyc%0d: got %0d expected %0d", cycleNo, drop_cnt, mDrops);
            end
`endif
            if (mBusy && cycleNo == gCycle + 1) begin
                checks++;
                if (pkt_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL valid_load cyc%0d: got %b expected 0", cycleNo, pkt_valid);
                end
                dropNow = mDrop;
            end else if (mBusy) begin
                checks++;
                if (pkt_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL valid_send cyc%0d: got %b expected 1", cycleNo, pkt_valid);
                end
                checks++;
                if (pkt_out !== expData) begin
                    errors++;
                    $display("[TB] FAIL pkt_out cyc%0d: got %h expected %h", cycleNo, pkt_out, expData);
                end
                checks++;
                if (grant_id !== 2'(mGrant)) begin
                    errors++;
                    $display("[TB] FAIL grant_id cyc%0d: got %0d expected %0d", cycleNo, grant_id, mGrant);
                end
                hs = pkt_ready;
            end else begin
                checks++;
                if (pkt_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL valid_idle cyc%0d: got %b expected 0", cycleNo, pkt_valid);
                end
            end
        end
        for (int i = 0; i < NP; i++) if (rdS[i] === 1'b1) rdSeen[i]++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rdS[i] === 1'b1 && fifoQ[i].size() > 0) dataReg[i] = fifoQ[i].pop_front();
        end
        if (rst) begin
            mBusy = 0; mLast = NP - 1; mSent = 0; mDrops = 0;
        end else begin
            if (expIdx >= 0) begin
                mBusy = 1; mGrant = expIdx; gCycle = cycleNo; expData = peek;
                mDrop = (int'(peek[11:8]) >= NP);
                grantLog.push_back(expIdx);
            end
            if (dropNow) begin
                mBusy = 0; mLast = mGrant; mDrops++;
            end
            if (hs) begin
                mBusy = 0; mLast = mGrant;
                if (mSent < 65535) mSent++;
            end
        end
        cycleNo++;
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while ((mBusy || anyEligible()) && n < maxc) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d cycles required below %0d", n, maxc);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) rdSeen[i] = 0;
        grantLog.delete();
    endtask

    task automatic test_reset();
        fifoQ[0].push_back(16'h0011);
        rst = 1'b1;
        cycle();
        cycle();
        cycle();
        checks++;
        if (pkt_out !== 16'h0 || pkt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pkt: got %h/%b required 0000/0", pkt_out, pkt_valid);
        end
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("[TB] FAIL reset_grant_id: got %0d required 3", grant_id);
        end
        checks++;
        if (pkt_sent_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got %0d required 0", pkt_sent_cnt);
        end
        checks++;
        if (rdSeen[0] != 0) begin
            errors++;
            $display("[TB] FAIL reset_rd: got %0d reads required 0", rdSeen[0]);
        end
        fifoQ[0].delete();
        doReset();
    endtask

    task automatic test_single();
        doReset();
        fifoQ[1].push_back(16'h30A5);
        pkt_ready = 1'b1;
        drain(20);
        cycle();
        checks++;
        if (grantLog.size() != 1 || grantLog[0] != 1 || rdSeen[1] != 1) begin
            errors++;
            $display("[TB] FAIL single_grant: got %0d grants, fifo1 reads %0d required 1/1", grantLog.size(), rdSeen[1]);
        end
        checks++;
        if (pkt_sent_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_cnt: got %0d required 1", pkt_sent_cnt);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        doReset();
        fifoQ[0].push_back(16'h0011);
        fifoQ[1].push_back(16'h1022);
        fifoQ[2].push_back(16'h2033);
        fifoQ[3].push_back(16'h3044);
        fifoQ[0].push_back(16'h0055);
        pkt_ready = 1'b1;
        drain(60);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (grantLog.size() <= k || grantLog[k] != order[k]) begin
                errors++;
                $display("[TB] FAIL rr_order[%0d]: got %0d required %0d", k,
                         (grantLog.size() > k) ? grantLog[k] : -1, order[k]);
            end
        end
        checks++;
        if (rdSeen[0] != 2 || rdSeen[1] != 1 || rdSeen[2] != 1 || rdSeen[3] != 1) begin
            errors++;
            $display("[TB] FAIL rr_reads: got %0d %0d %0d %0d required 2 1 1 1",
                     rdSeen[0], rdSeen[1], rdSeen[2], rdSeen[3]);
        end
    endtask

    task automatic test_backpressure();
        int rdDuring;
        doReset();
        pkt_ready = 1'b0;
        fifoQ[2].push_back(16'h20C3);
        fifoQ[3].push_back(16'h3011);
        for (int k = 0; k < 3; k++) cycle();
        rdDuring = rdSeen[0] + rdSeen[1] + rdSeen[2] + rdSeen[3];
        for (int k = 0; k < 10; k++) cycle();
        checks++;
        if (rdSeen[0] + rdSeen[1] + rdSeen[2] + rdSeen[3] != rdDuring) begin
            errors++;
            $display("[TB] FAIL stall_rd: got %0d reads required %0d",
                     rdSeen[0] + rdSeen[1] + rdSeen[2] + rdSeen[3], rdDuring);
        end
        pkt_ready = 1'b1;
        drain(30);
        cycle();
        checks++;
        if (pkt_sent_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL stall_cnt: got %0d required 2", pkt_sent_cnt);
        end
    endtask

    task automatic test_empty_gating();
        doReset();
        pkt_ready = 1'b1;
        fifoQ[1].push_back(16'h1255);
        fifoQ[3].push_back(16'h3177);
        for (int k = 0; k < 12; k++) cycle();
        checks++;
        if (rdSeen[2] != 0 || rdSeen[1] != 0 || rdSeen[3] != 0) begin
            errors++;
            $display("[TB] FAIL empty_gate: got reads %0d %0d %0d required 0 0 0", rdSeen[1], rdSeen[2], rdSeen[3]);
        end
        fifoQ[1].delete();
        fifoQ[3].delete();
    endtask

    task automatic test_reset_mid_load();
        int n = 0;
        doReset();
        pkt_ready = 1'b1;
        fifoQ[2].push_back(16'h2001);
        while (!mBusy && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (!mBusy) begin
            errors++;
            $display("[TB] FAIL midload_grant: got no grant required one within 10 cycles");
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (pkt_valid !== 1'b0 || grant_id !== 2'd3) begin
            errors++;
            $display("[TB] FAIL midload_reset: got valid %b grant %0d required 0/3", pkt_valid, grant_id);
        end
        grantLog.delete();
        fifoQ[3].push_back(16'h3002);
        fifoQ[0].push_back(16'h0003);
        drain(30);
        checks++;
        if (grantLog.size() != 2 || grantLog[0] != 0 || grantLog[1] != 3) begin
            errors++;
            $display("[TB] FAIL midload_order: got first %0d required 0 then 3",
                     (grantLog.size() > 0) ? grantLog[0] : -1);
        end
    endtask

    task automatic test_invalid_target();
        doReset();
        pkt_ready = 1'b1;
        fifoQ[3].push_back(16'h095A);
        for (int k = 0; k < 15; k++) cycle();
`ifdef OUT_ARB_DROP_INVALID_EN
        checks++;
        if (rdSeen[3] != 1 || drop_cnt !== 16'd1 || pkt_sent_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL invalid_drop: got reads %0d drops %0d sent %0d required 1/1/0",
                     rdSeen[3], drop_cnt, pkt_sent_cnt);
        end
`else
        checks++;
        if (rdSeen[3] != 0) begin
            errors++;
            $display("[TB] FAIL invalid_block: got %0d reads required 0", rdSeen[3]);
        end
`endif
        fifoQ[3].delete();
    endtask

    task automatic test_random();
        logic [15:0] p;
        int          f;
        doReset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                f = $urandom_range(0, NP - 1);
                if (fifoQ[f].size() < 4) begin
                    p = 16'($urandom);
                    p[11:8] = 4'($urandom_range(0, 3));
                    fifoQ[f].push_back(p);
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (fifoQ[i].size() > 0 && fifoQ[i][0][11:8] != 4'd0 && $urandom_range(0, 3) == 0)
                    void'(fifoQ[i].pop_front());
            end
            pkt_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        pkt_ready = 1'b1;
        drain(100);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            dataReg[i] = '0;
            rdSeen[i]  = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_empty_gating();
        test_reset_mid_load();
        test_invalid_target();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
